// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with majority-vote bit decisions, optional parity,
// 1/2 stop bits and a first-word-fall-through receive FIFO.
module uart_rx_param #(
  parameter int unsigned CLK_FREQ   = 20_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rx,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PW  = $clog2(OVERSAMPLE);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t                 state_q;
  logic                   sync1_q, sync2_q, prev_q;
  logic [DW-1:0]          div_q;
  logic [PW-1:0]          phase_q;
  logic                   s0_q, s1_q;
  logic [DATA_BITS-1:0]   data_q, push_data_q;
  logic [3:0]             bit_cnt_q;
  logic                   stop_cnt_q;
  logic                   par_bad_q, frm_q;
  logic                   push_q, parity_err_q, frame_err_q, overrun_q;

  logic                   rxs, tick, fall, samp_a, samp_b, decide, maj, exp_par, fault;

  always_comb begin
    rxs     = sync2_q;
    tick    = (div_q == DW'(DIV - 1));
    fall    = prev_q & ~rxs;
    samp_a  = tick && (phase_q == PW'(OVERSAMPLE/2 - 1));
    samp_b  = tick && (phase_q == PW'(OVERSAMPLE/2));
    decide  = tick && (phase_q == PW'(OVERSAMPLE/2 + 1));
    maj     = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
    exp_par = (PARITY == 1) ? ~(^data_q) : (^data_q);
    fault   = frm_q | ~maj;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      div_q   <= '0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      div_q   <= tick ? '0 : div_q + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      data_q       <= '0;
      push_data_q  <= '0;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      par_bad_q    <= 1'b0;
      frm_q        <= 1'b0;
      push_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      push_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (tick)   phase_q <= phase_q + PW'(1);
      if (samp_a) s0_q <= rxs;
      if (samp_b) s1_q <= rxs;
      case (state_q)
        S_IDLE: if (fall) begin
          state_q   <= S_START;
          phase_q   <= '0;
          par_bad_q <= 1'b0;
          frm_q     <= 1'b0;
        end
        S_START: if (decide) begin
          state_q   <= maj ? S_IDLE : S_DATA;
          bit_cnt_q <= '0;
        end
        S_DATA: if (decide) begin
          data_q <= {maj, data_q[DATA_BITS-1:1]};
          if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
            state_q    <= (PARITY != 0) ? S_PARITY : S_STOP;
            stop_cnt_q <= 1'b0;
          end else begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
        end
        S_PARITY: if (decide) begin
          par_bad_q <= (maj != exp_par);
          state_q   <= S_STOP;
        end
        S_STOP: if (decide) begin
          // Framing fault wins over parity; only the last stop bit resolves the frame.
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            if (fault) begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end else if (par_bad_q) begin
              parity_err_q <= 1'b1;
              state_q      <= S_IDLE;
            end else begin
              push_q      <= 1'b1;
              push_data_q <= data_q;
              state_q     <= S_IDLE;
            end
          end else begin
            frm_q      <= fault;
            stop_cnt_q <= 1'b1;
          end
        end
        S_WAIT_IDLE: if (rxs) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          cnt_q;
  logic                 pop, full, wr_en;

  always_comb begin
    pop   = (cnt_q != '0) && m_ready;
    full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
    wr_en = push_q && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_q && full && !pop;
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign m_valid    = (cnt_q != '0);
  assign m_data     = m_valid ? mem_q[rd_q] : '0;
  assign fifo_count = cnt_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three instances cover 8N1, even parity and 9-bit/2-stop frames.
module tb_uart_rx_param;

  localparam int unsigned CF  = 18_432_000;
  localparam int unsigned BR  = 115200;
  localparam int          BIT = 160;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic       rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic [7:0] md0, md1;
  logic [8:0] md2;
  logic       mv0, mv1, mv2;
  logic [3:0] fc0, fc1, fc2;
  logic       pe0_o, pe1_o, pe2_o, fe0_o, fe1_o, fe2_o, ov0_o, ov1_o, ov2_o;

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR)) u0 (
    .clk(clk), .rst_n(rst_n), .rx(rx0), .m_data(md0), .m_valid(mv0), .m_ready(rdy0),
    .fifo_count(fc0), .parity_err(pe0_o), .frame_err(fe0_o), .overrun(ov0_o));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .PARITY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .rx(rx1), .m_data(md1), .m_valid(mv1), .m_ready(rdy1),
    .fifo_count(fc1), .parity_err(pe1_o), .frame_err(fe1_o), .overrun(ov1_o));

  uart_rx_param #(.CLK_FREQ(CF), .BAUD_RATE(BR), .DATA_BITS(9), .STOP_BITS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .rx(rx2), .m_data(md2), .m_valid(mv2), .m_ready(rdy2),
    .fifo_count(fc2), .parity_err(pe2_o), .frame_err(fe2_o), .overrun(ov2_o));

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] got0 [32];
  logic [8:0] got1 [32];
  logic [8:0] got2 [32];
  int n0 = 0, n1 = 0, n2 = 0;
  int pe0 = 0, pe1 = 0, pe2 = 0, fe0 = 0, fe1 = 0, fe2 = 0, ov0 = 0, ov1 = 0, ov2 = 0;

  // Record every accepted word and every error pulse.
  always @(negedge clk) begin
    if (mv0 && rdy0 && n0 < 32) begin got0[n0] = {1'b0, md0}; n0++; end
    if (mv1 && rdy1 && n1 < 32) begin got1[n1] = {1'b0, md1}; n1++; end
    if (mv2 && rdy2 && n2 < 32) begin got2[n2] = md2; n2++; end
    if (pe0_o) pe0++;
    if (pe1_o) pe1++;
    if (pe2_o) pe2++;
    if (fe0_o) fe0++;
    if (fe1_o) fe1++;
    if (fe2_o) fe2++;
    if (ov0_o) ov0++;
    if (ov1_o) ov1++;
    if (ov2_o) ov2++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    case (ch)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_frame(input int ch, input logic [8:0] d, input int nbits,
                            input bit has_par, input logic pbit,
                            input int nstop, input logic [1:0] stopv);
    set_rx(ch, 1'b0);
    wait_clk(BIT);
    for (int i = 0; i < nbits; i++) begin
      set_rx(ch, d[i]);
      wait_clk(BIT);
    end
    if (has_par) begin
      set_rx(ch, pbit);
      wait_clk(BIT);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(ch, stopv[i]);
      wait_clk(BIT);
    end
    set_rx(ch, 1'b1);
  endtask

  initial begin
    #3;
    check("rst_mvalid", 32'(mv0), 32'd0);
    check("rst_count",  32'(fc0), 32'd0);
    check("rst_mdata",  32'(md0), 32'd0);
    check("rst_flags",  32'({pe0_o, fe0_o, ov0_o}), 32'd0);
    check("rst_mdata9", 32'(md2), 32'd0);
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2 * BIT);

    // 0xA5 8N1
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11);
    wait_clk(2 * BIT);
    check("a5_n",    32'(n0), 32'd1);
    check("a5_data", 32'(got0[0]), 32'h0A5);
    check("a5_pe",   32'(pe0), 32'd0);
    check("a5_fe",   32'(fe0), 32'd0);
    check("a5_ov",   32'(ov0), 32'd0);

    // 0x3C even parity: four ones, correct parity bit is 0
    send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1, 2'b11);
    wait_clk(2 * BIT);
    check("par_bad_pe",    32'(pe1), 32'd1);
    check("par_bad_n",     32'(n1), 32'd0);
    check("par_bad_count", 32'(fc1), 32'd0);
    send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1, 2'b11);
    wait_clk(2 * BIT);
    check("par_ok_n",    32'(n1), 32'd1);
    check("par_ok_data", 32'(got1[0]), 32'h03C);
    check("par_ok_pe",   32'(pe1), 32'd1);

    // short glitch, then a long break
    rx0 = 1'b0;
    wait_clk(40);
    rx0 = 1'b1;
    wait_clk(2 * BIT);
    check("glitch_n",  32'(n0), 32'd1);
    check("glitch_fe", 32'(fe0), 32'd0);
    check("glitch_mv", 32'(mv0), 32'd0);
    rx0 = 1'b0;
    wait_clk(20 * BIT);
    rx0 = 1'b1;
    wait_clk(2 * BIT);
    check("break_fe", 32'(fe0), 32'd1);
    check("break_n",  32'(n0), 32'd1);
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 2'b11);
    wait_clk(2 * BIT);
    check("after_break_n",    32'(n0), 32'd2);
    check("after_break_data", 32'(got0[1]), 32'h055);
    check("after_break_fe",   32'(fe0), 32'd1);

    // fill the FIFO and overrun it
    rdy0 = 1'b0;
    for (int b = 1; b <= 8; b++) send_frame(0, 9'(b), 8, 1'b0, 1'b0, 1, 2'b11);
    wait_clk(BIT);
    check("full_count", 32'(fc0), 32'd8);
    check("full_ov",    32'(ov0), 32'd0);
    send_frame(0, 9'h009, 8, 1'b0, 1'b0, 1, 2'b11);
    wait_clk(BIT);
    check("ovr_pulse", 32'(ov0), 32'd1);
    check("ovr_count", 32'(fc0), 32'd8);
    rdy0 = 1'b1;
    wait_clk(20);
    check("drain_n", 32'(n0), 32'd10);
    for (int k = 0; k < 8; k++) check($sformatf("drain_%0d", k), 32'(got0[2 + k]), 32'(k + 1));
    check("drain_count", 32'(fc0), 32'd0);

    // 9 data bits, 2 stop bits
    send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 2, 2'b11);
    send_frame(2, 9'h100, 9, 1'b0, 1'b0, 2, 2'b01);
    wait_clk(2 * BIT);
    check("nine_n",    32'(n2), 32'd1);
    check("nine_data", 32'(got2[0]), 32'h1FF);
    check("nine_fe",   32'(fe2), 32'd1);
    check("nine_pe",   32'(pe2), 32'd0);

    // reset during data bit 3 of 0xF8 (line high there and for the rest of the frame)
    fork
      send_frame(0, 9'h0F8, 8, 1'b0, 1'b0, 1, 2'b11);
      begin
        wait_clk(4 * BIT + 60);
        rst_n = 1'b0;
        wait_clk(20);
        rst_n = 1'b1;
      end
    join
    wait_clk(2 * BIT);
    check("rst_abort_n",  32'(n0), 32'd10);
    check("rst_abort_fe", 32'(fe0), 32'd1);
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 2'b11);
    wait_clk(2 * BIT);
    check("post_rst_n",    32'(n0), 32'd11);
    check("post_rst_data", 32'(got0[10]), 32'h07E);
    check("post_rst_pe",   32'(pe0), 32'd0);
    check("post_rst_fe",   32'(fe0), 32'd1);
    check("post_rst_ov",   32'(ov0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
